// File: rtl/alu_trace_pkg.sv
// Shared constants, field layout and state type for the ALU trace recorder.
// The packed word matches the 35-bit ALU test-vector line: {op,a,b,sl,simm,r,flags}.
package alu_trace_pkg;

   localparam int VEC_W = 35;

   localparam int OP_W    = 3;
   localparam int A_W     = 8;
   localparam int B_W     = 8;
   localparam int SL_W    = 1;
   localparam int SIMM_W  = 3;
   localparam int R_W     = 8;
   localparam int FLAGS_W = 4;

   localparam int FLAGS_LSB = 0;
   localparam int R_LSB     = FLAGS_LSB + FLAGS_W;
   localparam int SIMM_LSB  = R_LSB + R_W;
   localparam int SL_LSB    = SIMM_LSB + SIMM_W;
   localparam int B_LSB     = SL_LSB + SL_W;
   localparam int A_LSB     = B_LSB + B_W;
   localparam int OP_LSB    = A_LSB + A_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECORD,
      ST_DRAIN
   } state_t;

   // Opcode lands in the MSBs and flags in the LSBs so a dump reads as a vector file.
   function automatic logic [VEC_W-1:0] pack_trace(
      input logic [OP_W-1:0]    op,
      input logic [A_W-1:0]     a,
      input logic [B_W-1:0]     b,
      input logic [SL_W-1:0]    sl,
      input logic [SIMM_W-1:0]  simm,
      input logic [R_W-1:0]     r,
      input logic [FLAGS_W-1:0] flags
   );
      logic [VEC_W-1:0] w;
      w = '0;
      w[OP_LSB    +: OP_W]    = op;
      w[A_LSB     +: A_W]     = a;
      w[B_LSB     +: B_W]     = b;
      w[SL_LSB    +: SL_W]    = sl;
      w[SIMM_LSB  +: SIMM_W]  = simm;
      w[R_LSB     +: R_W]     = r;
      w[FLAGS_LSB +: FLAGS_W] = flags;
      return w;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// The read register holds its value whenever rd_en is low, which the drain path relies on.
module trace_ram #(
   parameter int DEPTH = 1024,
   parameter int VEC_W = 35,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [VEC_W-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [VEC_W-1:0] rd_data
);

   logic [VEC_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/alu_trace_recorder.sv
// Records packed ALU transactions into trace_ram while armed, then drains them
// in capture order over a valid/ready port once stopped.
module alu_trace_recorder #(
   parameter int DEPTH = 1024,
   parameter int VEC_W = 35,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arm,
   input  logic             stop,
   input  logic             cap_valid,
   input  logic [2:0]       cap_op,
   input  logic [7:0]       cap_a,
   input  logic [7:0]       cap_b,
   input  logic             cap_sl,
   input  logic [2:0]       cap_simm,
   input  logic [7:0]       cap_r,
   input  logic [3:0]       cap_flags,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [VEC_W-1:0] rd_data,
   output logic             rd_last,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             busy
);

   import alu_trace_pkg::*;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_t           state;
   logic [CW-1:0]    rd_ptr;
   logic             room;
   logic             take;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [VEC_W-1:0] wr_data;
   logic             advance;
   logic             fetch;

   assign wr_data = VEC_W'(pack_trace(cap_op, cap_a, cap_b, cap_sl, cap_simm, cap_r, cap_flags));
   assign busy    = (state != ST_IDLE);

   // An arm restarts at index 0, so a capture alongside it always has room.
   // The output word is the RAM read register itself: a fetch is only issued
   // when the current word is absent or being accepted, so stalls hold it.
   always_comb begin
      room    = (count < FULL);
      take    = cap_valid && (arm || room);
      wr_en   = (state == ST_RECORD) && take && !reset;
      wr_addr = arm ? '0 : count[AW-1:0];
      advance = !rd_valid || rd_ready;
      fetch   = (state == ST_DRAIN) && advance && (rd_ptr < count) && !reset;
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .VEC_W (VEC_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (fetch),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         count    <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_ptr   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arm) begin
                  state    <= ST_RECORD;
                  count    <= '0;
                  overflow <= 1'b0;
               end
            end

            ST_RECORD: begin
               if (arm) begin
                  count    <= cap_valid ? CW'(1) : '0;
                  overflow <= 1'b0;
               end else begin
                  if (cap_valid) begin
                     if (room) begin
                        count <= count + 1'b1;
                     end else begin
                        overflow <= 1'b1;
                     end
                  end
                  if (stop) begin
                     rd_ptr <= '0;
                     state  <= ((count != '0) || (cap_valid && room)) ? ST_DRAIN : ST_IDLE;
                  end
               end
            end

            ST_DRAIN: begin
               if (rd_valid && rd_ready && rd_last) begin
                  state    <= ST_IDLE;
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
               end else if (fetch) begin
                  rd_valid <= 1'b1;
                  rd_last  <= (rd_ptr == count - CW'(1));
                  rd_ptr   <= rd_ptr + 1'b1;
               end else if (advance) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_trace_recorder.sv
// Randomized and directed bench for alu_trace_recorder, checked every cycle
// against a queue-based model of the recorder's record/drain behaviour.
module tb_alu_trace_recorder;

   localparam int DEPTH = 8;
   localparam int VEC_W = 35;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             arm;
   logic             stop;
   logic             cap_valid;
   logic [2:0]       cap_op;
   logic [7:0]       cap_a;
   logic [7:0]       cap_b;
   logic             cap_sl;
   logic [2:0]       cap_simm;
   logic [7:0]       cap_r;
   logic [3:0]       cap_flags;
   logic             rd_valid;
   logic             rd_ready;
   logic [VEC_W-1:0] rd_data;
   logic             rd_last;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             busy;

   int total = 0;
   int bad   = 0;

   typedef enum int {M_IDLE, M_REC, M_DRAIN} mode_t;
   mode_t            m_mode = M_IDLE;
   logic [VEC_W-1:0] m_q[$];
   logic             m_ovf   = 1'b0;
   logic             m_valid = 1'b0;
   int               m_idx   = 0;

   always #5 clk = ~clk;

   alu_trace_recorder #(
      .DEPTH (DEPTH),
      .VEC_W (VEC_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .arm       (arm),
      .stop      (stop),
      .cap_valid (cap_valid),
      .cap_op    (cap_op),
      .cap_a     (cap_a),
      .cap_b     (cap_b),
      .cap_sl    (cap_sl),
      .cap_simm  (cap_simm),
      .cap_r     (cap_r),
      .cap_flags (cap_flags),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .count     (count),
      .overflow  (overflow),
      .busy      (busy)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: the trace is a queue; drain presents queue[m_idx] starting one edge after the stop edge.
   task automatic model_edge();
      logic [VEC_W-1:0] word;
      word = {cap_op, cap_a, cap_b, cap_sl, cap_simm, cap_r, cap_flags};
      if (reset) begin
         m_mode  = M_IDLE;
         m_q.delete();
         m_ovf   = 1'b0;
         m_valid = 1'b0;
         m_idx   = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (arm) begin
                  m_mode = M_REC;
                  m_q.delete();
                  m_ovf  = 1'b0;
               end
            end
            M_REC: begin
               if (arm) begin
                  m_q.delete();
                  m_ovf = 1'b0;
                  if (cap_valid) m_q.push_back(word);
               end else begin
                  if (cap_valid) begin
                     if (m_q.size() < DEPTH) m_q.push_back(word);
                     else m_ovf = 1'b1;
                  end
                  if (stop) begin
                     if (m_q.size() > 0) begin
                        m_mode  = M_DRAIN;
                        m_valid = 1'b0;
                        m_idx   = 0;
                     end else begin
                        m_mode = M_IDLE;
                     end
                  end
               end
            end
            M_DRAIN: begin
               if (!m_valid) begin
                  m_valid = 1'b1;
               end else if (rd_ready) begin
                  if (m_idx == m_q.size() - 1) begin
                     m_mode  = M_IDLE;
                     m_valid = 1'b0;
                  end else begin
                     m_idx++;
                  end
               end
            end
            default: m_mode = M_IDLE;
         endcase
      end
   endtask

   task automatic set_cap(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic sl, input logic [2:0] simm, input logic [7:0] r, input logic [3:0] fl);
      cap_valid = v;
      cap_op    = op;
      cap_a     = a;
      cap_b     = b;
      cap_sl    = sl;
      cap_simm  = simm;
      cap_r     = r;
      cap_flags = fl;
   endtask

   task automatic rand_cap(input logic v);
      set_cap(v, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              3'($urandom), 8'($urandom), 4'($urandom));
   endtask

   // One clock: drive controls, advance the model on the edge, compare #1 later.
   task automatic applyStimulus(input logic a_arm, input logic a_stop, input logic a_ready, input logic a_reset);
      arm      = a_arm;
      stop     = a_stop;
      rd_ready = a_ready;
      reset    = a_reset;
      @(posedge clk);
      model_edge();
      #1;
      checkOutput("rd_valid", 64'(rd_valid), 64'(m_valid));
      checkOutput("rd_last", 64'(rd_last), 64'(m_valid && (m_idx == m_q.size() - 1)));
      if (m_valid) checkOutput("rd_data", 64'(rd_data), 64'(m_q[m_idx]));
      checkOutput("count", 64'(count), 64'(m_q.size()));
      checkOutput("overflow", 64'(overflow), 64'(m_ovf));
      checkOutput("busy", 64'(busy), 64'(m_mode != M_IDLE));
   endtask

   initial begin
      set_cap(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0, 4'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("reset_count", 64'(count), 64'(0));
      checkOutput("reset_busy", 64'(busy), 64'(0));

      // Single capture of a known ALU transaction.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      set_cap(1'b1, 3'b010, 8'h0F, 8'h01, 1'b0, 3'b000, 8'h10, 4'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      set_cap(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0, 4'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("single_gap", 64'(rd_valid), 64'(0));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("single_word", 64'(rd_data), 64'(35'h2_0F01_0100));
      checkOutput("single_last", 64'(rd_last), 64'(1));
      checkOutput("single_count", 64'(count), 64'(1));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("single_idle", 64'(busy), 64'(0));

      // Five captures, drained back-to-back.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         rand_cap(1'b1);
         cap_a = 8'(i);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      end
      cap_valid = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         checkOutput("burst_valid", 64'(rd_valid), 64'(1));
         checkOutput("burst_a", 64'(rd_data[31:24]), 64'(k + 1));
         checkOutput("burst_last", 64'(rd_last), 64'(k == 4));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("burst_done", 64'(rd_valid), 64'(0));

      // Same burst drained with ready pattern 1,0,0,1,0,0,...
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         rand_cap(1'b1);
         cap_a = 8'(i);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
      cap_valid = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 1'b0, 1'((k % 3) == 0), 1'b0);
      end
      checkOutput("stall_done", 64'(busy), 64'(0));

      // Overflow: two more captures than the buffer holds.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) begin
         rand_cap(1'b1);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      end
      cap_valid = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("ovf_count", 64'(count), 64'(DEPTH));
      checkOutput("ovf_flag", 64'(overflow), 64'(1));
      for (int k = 0; k < DEPTH + 3; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Empty stop returns to idle; arm+stop together keeps recording.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("empty_idle", 64'(busy), 64'(0));
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("armstop_busy", 64'(busy), 64'(1));
      checkOutput("armstop_count", 64'(count), 64'(0));
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

      // Re-arm with capture mid-record, then capture in the stop cycle.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         rand_cap(1'b1);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      end
      rand_cap(1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("rearm_count", 64'(count), 64'(1));
      rand_cap(1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      rand_cap(1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("stopcap_count", 64'(count), 64'(3));
      for (int k = 0; k < 6; k++) begin
         rand_cap(1'($urandom));
         applyStimulus(1'($urandom), 1'($urandom), 1'b1, 1'b0);
      end
      cap_valid = 1'b0;

      // Reset in the middle of a drain.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rand_cap(1'b1);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      end
      cap_valid = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("abort_valid", 64'(rd_valid), 64'(0));
      checkOutput("abort_count", 64'(count), 64'(0));
      checkOutput("abort_ovf", 64'(overflow), 64'(0));
      checkOutput("abort_busy", 64'(busy), 64'(0));
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      // Random traffic.
      for (int n = 0; n < 4000; n++) begin
         rand_cap(1'($urandom_range(0, 1)));
         applyStimulus(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 14) == 0),
                       1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 299) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_trace_recorder.md
ALU_TRACE_RECORDER -- requirements
Module: alu_trace_recorder

Interface
REQ-001 Parameter DEPTH, default 1024, number of trace entries (power of two).
REQ-002 Parameter VEC_W, default 35, packed trace word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 arm  in  1  pulse: clear buffer and start recording.
REQ-006 stop  in  1  pulse: end recording and begin drain.
REQ-007 cap_valid  in  1  capture the current ALU transaction this cycle.
REQ-008 cap_op  in  3  ALU opcode.
REQ-009 cap_a, cap_b  in  8 each  ALU operands.
REQ-010 cap_sl  in  1  shift_logical.
REQ-011 cap_simm  in  3  shift immediate.
REQ-012 cap_r  in  8  ALU result.
REQ-013 cap_flags  in  4  ALU flags.
REQ-014 rd_valid  out  1  rd_data holds a trace word.
REQ-015 rd_ready  in  1  consumer accepts the word.
REQ-016 rd_data  out  VEC_W  packed word {op,a,b,sl,simm,r,flags}, op in MSBs, flags in LSBs.
REQ-017 rd_last  out  1  rd_data is the final captured word.
REQ-018 count  out  log2(DEPTH)+1  number of words captured.
REQ-019 overflow  out  1  sticky: a capture was dropped because the buffer was full.
REQ-020 busy  out  1  high in RECORD or DRAIN.

Function
REQ-021 FSM states IDLE, RECORD, DRAIN; encoding is free.
REQ-022 IDLE: arm -> RECORD, count:=0, overflow:=0; stop ignored; cap_valid ignored.
REQ-023 RECORD: cap_valid with count<DEPTH writes the packed word at index count, count increments next cycle.
REQ-024 RECORD: cap_valid with count==DEPTH drops the word and sets overflow; FSM stays in RECORD.
REQ-025 RECORD: arm restarts (count:=0, overflow:=0); any simultaneous cap_valid is the new entry 0.
REQ-026 RECORD: stop -> DRAIN if count (including a same-cycle capture) >0, else -> IDLE; a capture in the stop cycle is recorded.
REQ-027 RECORD: arm and stop in the same cycle -> arm wins.
REQ-028 DRAIN: words presented in capture order, index 0 first; first rd_valid in the second cycle after the stop cycle.
REQ-029 Transfer occurs when rd_valid && rd_ready; rd_data, rd_last hold stable while rd_valid && !rd_ready.
REQ-030 With rd_ready held high, throughput is one word per cycle, no bubbles.
REQ-031 rd_last high only with the word at index count-1; its transfer -> IDLE, rd_valid low the next cycle.
REQ-032 DRAIN: arm, stop, cap_valid are ignored; count and overflow hold.
REQ-033 rd_valid and rd_last are low outside DRAIN.

Reset
REQ-034 Reset forces IDLE, rd_valid=0, rd_last=0, count=0, overflow=0, busy=0; rd_data is don't-care while rd_valid=0.
REQ-035 Reset mid-RECORD or mid-DRAIN aborts immediately; no further words are presented; RAM contents are not cleared.

Structure
REQ-036 Package alu_trace_pkg holds VEC_W, field widths/offsets (op 3, a 8, b 8, sl 1, simm 3, r 8, flags 4) and the state enum.
REQ-037 Storage is a sub-module trace_ram: simple dual-port, synchronous read, one write and one read port, DEPTH x VEC_W.
REQ-038 Packing order matches the 35-bit test-vector line layout used by the ALU bench, so a dump is directly loadable as a vector file.

Verification
REQ-039 arm; one capture op=010 a=0F b=01 sl=0 simm=000 r=10 flags=0000; stop; rd_ready=1 -> one word = those fields packed, rd_last=1, count=1, then IDLE.
REQ-040 arm; 5 captures with a=01..05 on consecutive cycles; stop; rd_ready=1 -> a=01..05 on 5 consecutive cycles, rd_last only on a=05.
REQ-041 Same as REQ-040 with rd_ready toggling 1,0,0,1,... -> rd_data stable during stalls, no word lost or duplicated.
REQ-042 DEPTH=4: arm; 6 captures; stop -> count=4, overflow=1, first 4 words drained, rd_last on 4th.
REQ-043 arm; stop with no captures -> IDLE next cycle, rd_valid never asserted; arm+stop same cycle in RECORD -> remains RECORD, count=0.
REQ-044 Reset asserted during DRAIN after 2 of 5 words -> next cycle IDLE, rd_valid=0, count=0, overflow=0.
